multiword_add_ctrl: RTL and testbench
=====================================

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 4, from 4 to 64.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operands present.
REQ-005 SHALL have port in_ready, output, 1, controller accepts operands.
REQ-006 SHALL have port a, input, WIDTH, operand A.
REQ-007 SHALL have port b, input, WIDTH, operand B.
REQ-008 SHALL have port cin, input, 1, carry-in for the least significant nibble.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port sum, output, WIDTH, result.
REQ-012 SHALL have port cout, output, 1, carry out of the most significant nibble.
REQ-013 SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-014 SHALL compute the result with exactly one structural 4-bit ripple-carry adder slice, time-multiplexed over NNIB = WIDTH/4 nibbles, LSB nibble first.
REQ-015 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-016 SHALL, in IDLE, drive in_ready=1; an input is accepted when in_valid&&in_ready; on acceptance, SHALL register a, b and cin, clear the nibble counter to 0 and move to RUN.
REQ-017 SHALL, in each RUN cycle, feed slice inputs from nibble[cnt] of the registered A and B, plus the carry register, which holds cin on the first RUN cycle.
REQ-018 SHALL, in each RUN cycle, write the slice sum into sum nibble[cnt] and the slice carry-out into the carry register, then increment cnt.
REQ-019 SHALL move from RUN to DONE after the cycle with cnt==NNIB-1; RUN lasts exactly NNIB cycles.
REQ-020 SHALL, in DONE, drive out_valid=1 with sum and cout stable, and drive cout equal to the final carry register.
REQ-021 SHALL hold DONE while out_ready=0, and return to IDLE on the cycle out_valid&&out_ready.
REQ-022 SHALL put out_valid high exactly NNIB+1 cycles after the acceptance edge; the minimum initiation interval is NNIB+2 cycles.
REQ-023 SHALL hold in_ready=0 in RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT disturb the registered operands.
REQ-024 SHALL change a, b and cin only on acceptance; changes on those inputs mid-RUN SHALL have no effect.
REQ-025 SHALL hold sum and cout at their last values in IDLE until the next RUN overwrites them.
REQ-026 SHALL wrap the result modulo 2^WIDTH; the final carry appears only on cout (for example, all-ones + 1 gives sum=0, cout=1).
REQ-027 SHALL never drive in_ready and out_valid high in the same cycle.

Reset
REQ-028 SHALL, while rst_n=0, immediately force: state=IDLE, cnt=0, carry register=0, operand registers=0, sum=0, cout=0, out_valid=0, busy=0.
REQ-029 SHALL drive in_ready=1 during reset.
REQ-030 SHALL, on reset asserted mid-RUN or in DONE, abandon the operation; no out_valid SHALL follow for it.
REQ-031 SHALL, after rst_n deasserts, accept a new operation on the first rising edge with in_valid=1.

Configuration
REQ-032 SHALL, when macro MULTIWORD_ADD_CTRL_SUB_EN is defined, add input port op_sub (1 bit), registered on acceptance.
REQ-033 SHALL, with the macro defined and op_sub=1, feed ~B nibbles to the slice and load the carry register with 1 (ignore cin), giving A-B modulo 2^WIDTH with cout=1 meaning no borrow; with op_sub=0, behaviour SHALL be identical to REQ-017.
REQ-034 SHALL, when the macro is undefined, have no op_sub port, no inversion logic, and perform addition only.

Verification
REQ-035 SHALL verify, WIDTH=16: a=0xFFFF, b=0x0001, cin=0 -> out_valid 5 cycles after acceptance, sum=0x0000, cout=1.
REQ-036 SHALL verify: a=0x1234, b=0x4321, cin=1 with out_ready held 0 for 3 cycles -> sum=0x5556, cout=0, outputs stable throughout DONE, in_ready=0 until the handshake.
REQ-037 SHALL verify: in_valid pulsed with a=0xAAAA in RUN cycle 2 -> ignored; result is unchanged from the original operands.
REQ-038 SHALL verify: rst_n pulsed low during RUN cycle 3 -> all outputs zero immediately, in_ready=1, no out_valid afterward; the next operation completes correctly.
REQ-039 SHALL verify, with MULTIWORD_ADD_CTRL_SUB_EN defined: a=0x0005, b=0x0007, op_sub=1 -> sum=0xFFFE, cout=0; with a=0x0007, b=0x0005, op_sub=1 -> sum=0x0002, cout=1.
REQ-040 SHALL verify, WIDTH=4: a=0x9, b=0x8 -> out_valid 2 cycles after acceptance, sum=0x1, cout=1.

Source files
------------

// File: rtl/multiword_add_ctrl.sv
// Multi-word adder controller: one 4-bit ripple-carry slice reused nibble by nibble, LSB first.
// Optional subtract mode is enabled by defining MULTIWORD_ADD_CTRL_SUB_EN.

module multiword_add_ctrl_rca4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  // Four chained full adders; carry ripples from bit 0 to bit 3
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[4];

endmodule

module multiword_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NNIB = WIDTH / 4;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  assign nib_a = 4'(a_reg >> {cnt, 2'b00});

`ifdef MULTIWORD_ADD_CTRL_SUB_EN
  logic sub_reg;

  // Subtraction is A + ~B + 1; the +1 enters through the preloaded carry
  assign nib_b = 4'(b_reg >> {cnt, 2'b00}) ^ {4{sub_reg}};
`else
  assign nib_b = 4'(b_reg >> {cnt, 2'b00});
`endif

  multiword_add_ctrl_rca4 u_slice (
    .x  (nib_a),
    .y  (nib_b),
    .ci (carry),
    .s  (nib_sum),
    .co (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
            sub_reg  <= op_sub;
            carry    <= op_sub ? 1'b1 : cin;
`else
            carry    <= cin;
`endif
          end
        end
        RUN: begin
          for (int i = 0; i < NNIB; i++) begin
            if (cnt == CW'(i)) sum[i*4 +: 4] <= nib_sum;
          end
          carry <= nib_cout;
          cnt   <= cnt + 1'b1;
          // Last nibble: the slice carry becomes the visible carry out
          if (cnt == LAST) begin
            cout      <= nib_cout;
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench for multiword_add_ctrl: 16-bit and 4-bit instances against an arithmetic model.
// Subtract cases are exercised when MULTIWORD_ADD_CTRL_SUB_EN is defined.

module tb_multiword_add_ctrl;

  localparam int W  = 16;
  localparam int NN = W / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy, op_sub;
  logic [15:0] a, b, sum;

  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4, op_sub4;
  logic [3:0]  a4, b4, sum4;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiword_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  multiword_add_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
    .op_sub    (op_sub4),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4),
    .busy      (busy4)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 16-bit operation: hold = cycles out_ready stays low in DONE, pulse_at = RUN cycle with a stray in_valid
  task automatic apply_stimulus(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                                input logic tsub, input int hold, input int pulse_at);
    logic [15:0] es;
    logic        ec;
    int          lat;
    if (tsub) begin
      es = ta - tb;
      ec = (ta >= tb);
    end else begin
      {ec, es} = 17'(ta) + 17'(tb) + 17'(tcin);
    end
    @(negedge clk);
    a = ta; b = tb; cin = tcin; op_sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    check_output("in_ready_idle", in_ready, 1);
    check_output("out_valid_idle", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (lat = 1; lat <= NN + 3; lat++) begin
      if (out_valid) break;
      check_output("in_ready_run", in_ready, 0);
      check_output("busy_run", busy, 1);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
      if (lat == pulse_at) begin
        in_valid = 1'b1;
        a = 16'hAAAA;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_output("latency", 64'(lat), 64'(NN + 1));
    for (int h = 0; h <= hold; h++) begin
      check_output("out_valid_done", out_valid, 1);
      check_output("in_ready_done", in_ready, 0);
      check_output("sum_done", sum, es);
      check_output("cout_done", cout, ec);
      if (h < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("out_valid_after", out_valid, 0);
    check_output("in_ready_after", in_ready, 1);
    check_output("busy_after", busy, 0);
    check_output("sum_held", sum, es);
    check_output("cout_held", cout, ec);
  endtask

  task automatic apply_stimulus4(input logic [3:0] ta, input logic [3:0] tb, input logic tcin);
    logic [3:0] es;
    logic       ec;
    int         lat;
    {ec, es} = 5'(ta) + 5'(tb) + 5'(tcin);
    @(negedge clk);
    a4 = ta; b4 = tb; cin4 = tcin; in_valid4 = 1'b1; out_ready4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    for (lat = 1; lat <= 4; lat++) begin
      if (out_valid4) break;
      a4 = 4'($urandom); b4 = 4'($urandom);
      @(negedge clk);
    end
    check_output("w4_latency", 64'(lat), 64'(2));
    check_output("w4_sum", sum4, es);
    check_output("w4_cout", cout4, ec);
    check_output("w4_in_ready", in_ready4, 0);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check_output("w4_out_valid_after", out_valid4, 0);
  endtask

  initial begin
    logic seen;
    in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; op_sub = 0;
    in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; cin4 = 0; op_sub4 = 0;

    #1 rst_n = 1'b0;
    #2;
    check_output("rst_sum", sum, 0);
    check_output("rst_cout", cout, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_in_ready4", in_ready4, 1);
    check_output("rst_sum4", sum4, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
    apply_stimulus(16'h1234, 16'h4321, 1'b1, 1'b0, 3, 0);
    apply_stimulus(16'h0F0F, 16'h1010, 1'b0, 1'b0, 1, 2);

    // Reset in RUN cycle 3, after two nibbles of sum have been written
    @(negedge clk);
    a = 16'h7777; b = 16'h1111; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("midrun_rst_sum", sum, 0);
    check_output("midrun_rst_cout", cout, 0);
    check_output("midrun_rst_out_valid", out_valid, 0);
    check_output("midrun_rst_busy", busy, 0);
    check_output("midrun_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < NN + 3; i++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check_output("no_valid_after_rst", seen, 0);
    apply_stimulus(16'h7777, 16'h1111, 1'b0, 1'b0, 0, 0);

`ifdef MULTIWORD_ADD_CTRL_SUB_EN
    apply_stimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 0);
    apply_stimulus(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 0);
`endif

    for (int n = 0; n < 24; n++) begin
      logic s;
`ifdef MULTIWORD_ADD_CTRL_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      apply_stimulus(16'($urandom), 16'($urandom), 1'($urandom), s,
                     int'($urandom_range(0, 2)), int'($urandom_range(0, NN)));
    end

    apply_stimulus4(4'h9, 4'h8, 1'b0);
    apply_stimulus4(4'hF, 4'h0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      apply_stimulus4(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
